sample_collector: RTL and testbench
===================================

Name: sample_collector

Overview:
- Scheduler for the shared pin sample bus. It polls every enabled pin channel in round-robin order by driving output_sample and channel_select.
- It captures the OR-combined sample_data bus, detects new samples by watching each channel's 16-bit sample counter, and pushes new words into a FIFO.
- Sits between the pin channel array and the host readout path (command bus / USB bridge).

Parameters:
- NUM_CHANNELS, 16, number of pin channels polled; legal range 1..256.
- FIFO_AW, 6, FIFO address width; depth = 2^FIFO_AW words.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- enable  input  1  collection running; sampled at sweep start.
- clear  input  1  one-cycle pulse: flush FIFO, last-count table, sticky flags.
- channel_mask  input  NUM_CHANNELS  bit i=1 polls channel i.
- output_sample  output  1  registered sample request to all channels.
- channel_select  output  8  registered channel index being polled.
- sample_data  input  32  OR of all channel sample buses: {sample_cnt[15:0], position[14:0], pin_value}.
- rd_en  input  1  host pop request.
- rd_data  output  32  popped word, registered.
- rd_valid  output  1  rd_data valid; asserted for one cycle.
- fifo_empty  output  1  FIFO holds no words.
- fifo_count  output  FIFO_AW+1  words stored.
- overflow  output  1  sticky: a push was dropped because the FIFO was full.
- missed  output  1  sticky: a channel's count advanced by more than 1 between polls.
- sweep_done  output  1  one-cycle pulse after the last channel of a sweep is handled.

Behaviour:
- Reset: all outputs 0, except fifo_empty=1. FIFO pointers, last-count table, channel pointer and state all 0.
- FSM states are IDLE, REQ, CAP.
- IDLE:
  - If enable=1, set ptr=0 and go to REQ.
  - Otherwise stay in IDLE; output_sample=0 and channel_select=0.
- REQ, channel_mask[ptr]=1:
  - output_sample<=1, channel_select<=ptr.
  - Next state CAP.
  - Channels register sample_data on the edge ending this cycle.
- REQ, channel_mask[ptr]=0:
  - output_sample stays 0 and the pointer advances; each skipped channel costs 1 cycle.
  - If ptr was the last channel, pulse sweep_done and go to IDLE if enable=0, else wrap ptr to 0 and go to REQ.
- CAP:
  - output_sample<=0. sample_data is valid this cycle; let cnt=sample_data[31:16].
  - If cnt != last_cnt[ptr]: push sample_data and set last_cnt[ptr]<=cnt.
  - If (cnt - last_cnt[ptr]) mod 2^16 > 1 and last_cnt[ptr] != 0: set missed.
  - If cnt == last_cnt[ptr]: no push. This covers an idle or unresponsive channel (bus reads 0 when the table entry is 0).
  - Then advance ptr exactly as in REQ's end-of-sweep rule.
- Timing: one enabled channel costs 2 cycles. A full sweep of E enabled and S disabled channels costs 2E+S cycles.
- enable deassert mid-sweep: the current sweep completes; the block returns to IDLE after sweep_done.
- Counter wrap: 0xFFFF->0x0000 is a new sample (values differ) and does not set missed.
- FIFO full:
  - A push while full is dropped and sets overflow, even if rd_en is asserted the same cycle.
  - A simultaneous push and pop when not full both succeed; fifo_count is unchanged.
- Pop:
  - rd_en while !fifo_empty: rd_data<=head word, rd_valid=1 next cycle, count decrements.
  - rd_en while empty is ignored; rd_valid=0 and no flag is set.
- clear:
  - Resets FIFO pointers, the last-count table, overflow, missed and ptr.
  - Forces the FSM to IDLE on the next cycle. Has priority over push and pop.
  - Table clear may take NUM_CHANNELS cycles via a sweep, but must complete before the next REQ.
- sweep_done is not asserted in the cycle that clear is applied.

Test Plan:
- Mask 0x0005, channel 0 cnt 1 and channel 2 cnt 1 responding, enable=1 -> output_sample pulses with channel_select 0, then 2. Two FIFO pushes. sweep_done 6 cycles after enable (2+1+2+1). fifo_count=2.
- Second sweep with unchanged counts -> no pushes and fifo_count stays 2. Then channel 2 cnt becomes 2 -> exactly one push {0x0002, pos 2, value}.
- Channel 0 cnt jumps 1->4 between polls -> word pushed and missed=1. After clear -> missed=0, fifo_count=0, fifo_empty=1.
- FIFO_AW=2 with 4 words stored, new sample arrives with rd_en high the same cycle -> sample dropped, overflow=1, fifo_count=3. Next new sample -> accepted, count=4.
- Channel cnt 0xFFFF then 0x0000 -> both pushed, missed stays 0. Popping gives rd_valid one cycle after rd_en with the words in order.
- enable deasserted during CAP of channel 1 of 4 enabled channels -> channels 2 and 3 still polled, sweep_done pulses, FSM enters IDLE, output_sample stays 0 afterwards.

Source files
------------

// File: rtl/sample_collector_if.sv
// Shared pin sample bus plus the host readout port of the sample collector.
interface sample_collector_if #(
  parameter int FIFO_AW = 6
);
  logic               output_sample;
  logic [7:0]         channel_select;
  logic [31:0]        sample_data;
  logic               rd_en;
  logic [31:0]        rd_data;
  logic               rd_valid;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_count;

  modport master (
    output output_sample, channel_select, rd_data, rd_valid, fifo_empty, fifo_count,
    input  sample_data, rd_en
  );

  modport slave (
    input  output_sample, channel_select, rd_data, rd_valid, fifo_empty, fifo_count,
    output sample_data, rd_en
  );
endinterface

// File: rtl/sample_collector.sv
// Round-robin poller of the pin channel array: captures new samples off the
// shared OR bus (detected via each channel's sample counter) into a readout FIFO.
//
// state  | meaning
// S_IDLE | stopped; waits for enable to start a sweep at channel 0
// S_REQ  | channel ptr: request a sample if masked in, else skip it
// S_CAP  | channel ptr: sample_data valid, compare count, push if new
module sample_collector #(
  parameter int NUM_CHANNELS = 16,
  parameter int FIFO_AW      = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CHANNELS-1:0] channel_mask,
  sample_collector_if.master      bus,
  output logic                    overflow,
  output logic                    missed,
  output logic                    sweep_done
);
  localparam int PW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [PW-1:0] LAST_CH = PW'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            os_q, os_d;
  logic [7:0]      cs_q, cs_d;
  logic            sd_d;
  logic            advance;
  logic            new_sample;
  logic            miss_set;
  logic [15:0]     cap_cnt, cur_last, cnt_delta;
  logic [15:0]     last_cnt [NUM_CHANNELS];

  logic [31:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, count;
  logic             full, empty, do_push, do_pop;
  logic [31:0]      rd_data_q;
  logic             rd_valid_q;

  assign cap_cnt   = bus.sample_data[31:16];
  assign cur_last  = last_cnt[ptr_q];
  assign cnt_delta = cap_cnt - cur_last;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    os_d       = 1'b0;
    cs_d       = cs_q;
    sd_d       = 1'b0;
    advance    = 1'b0;
    new_sample = 1'b0;
    miss_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cs_d = 8'd0;
        if (enable) begin
          ptr_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (channel_mask[ptr_q]) begin
          os_d    = 1'b1;
          cs_d    = 8'(ptr_q);
          state_d = S_CAP;
        end else begin
          advance = 1'b1;
        end
      end
      S_CAP: begin
        new_sample = (cap_cnt != cur_last);
        // modulo-2^16 delta makes the 0xFFFF->0 wrap a clean single step
        miss_set   = new_sample && (cnt_delta > 16'd1) && (cur_last != 16'd0);
        advance    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (ptr_q == LAST_CH) begin
        sd_d    = 1'b1;
        ptr_d   = '0;
        state_d = enable ? S_REQ : S_IDLE;
      end else begin
        ptr_d   = ptr_q + 1'b1;
        state_d = S_REQ;
      end
    end
    if (clear) begin
      state_d    = S_IDLE;
      ptr_d      = '0;
      os_d       = 1'b0;
      cs_d       = 8'd0;
      sd_d       = 1'b0;
      new_sample = 1'b0;
      miss_set   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      os_q       <= 1'b0;
      cs_q       <= 8'd0;
      sweep_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      os_q       <= os_d;
      cs_q       <= cs_d;
      sweep_done <= sd_d;
    end
  end

  // The table is updated even when the push is dropped, so a lost word is not re-pushed.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_CHANNELS; i++) last_cnt[i] <= 16'd0;
    end else if (new_sample) begin
      last_cnt[ptr_q] <= cap_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      overflow <= 1'b0;
      missed   <= 1'b0;
    end else begin
      if (new_sample && full) overflow <= 1'b1;
      if (miss_set)           missed   <= 1'b1;
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (FIFO_AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = new_sample && !full;
  assign do_pop  = bus.rd_en && !empty && !clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= bus.sample_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= do_pop;
      if (do_pop) rd_data_q <= mem[rd_ptr[FIFO_AW-1:0]];
    end
  end

  assign bus.output_sample  = os_q;
  assign bus.channel_select = cs_q;
  assign bus.rd_data        = rd_data_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.fifo_empty     = empty;
  assign bus.fifo_count     = count;
endmodule

// File: tb/tb_sample_collector.sv
// Bench for sample_collector: directed sweep table, hand-written corner sequences,
// then random sweeps checked against a queue-based model of the collection rules.
module tb_sample_collector;
  localparam int NCH   = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           reset, enable, clear;
  logic [NCH-1:0] channel_mask;
  logic           overflow, missed, sweep_done;

  sample_collector_if #(.FIFO_AW(AW)) bus ();

  sample_collector #(.NUM_CHANNELS(NCH), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .channel_mask(channel_mask), .bus(bus),
    .overflow(overflow), .missed(missed), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] ch_cnt [NCH];

  function automatic logic [31:0] mkword(input int ch, input logic [15:0] c);
    return {c, 15'(ch), c[0]};
  endfunction

  // Channel array: the selected channel answers on the OR bus while requested.
  always_comb begin
    bus.sample_data = 32'd0;
    if (bus.output_sample && (bus.channel_select < 8'(NCH)))
      bus.sample_data = mkword(int'(bus.channel_select), ch_cnt[bus.channel_select[1:0]]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sweep_len(input logic [NCH-1:0] m);
    int n = 0;
    for (int i = 0; i < NCH; i++) n += m[i] ? 2 : 1;
    return n;
  endfunction

  int          sw_cycles;
  logic [7:0]  sw_sel [$];
  logic        sw_rdv;
  logic [31:0] sw_rdw;

  // k counts edges after the one that samples enable; sweep_done seen at k = sweep length.
  task automatic run_sweep(input logic [NCH-1:0] m, input int en_drop_at, input int rd_at);
    channel_mask = m;
    sw_sel.delete();
    sw_rdv    = 1'b0;
    sw_rdw    = 32'd0;
    sw_cycles = -1;
    enable    = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (bus.output_sample) sw_sel.push_back(bus.channel_select);
      if (bus.rd_valid) begin
        sw_rdv = 1'b1;
        sw_rdw = bus.rd_data;
      end
      if (sweep_done) begin
        sw_cycles  = k;
        enable     = 1'b0;
        bus.rd_en  = 1'b0;
        break;
      end
      if (k == en_drop_at) enable = 1'b0;
      bus.rd_en = (k == rd_at);
    end
    enable    = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic check_sel(input logic [NCH-1:0] m);
    logic [7:0] exp_sel [$];
    for (int i = 0; i < NCH; i++) if (m[i]) exp_sel.push_back(8'(i));
    chk("poll_count", sw_sel.size(), exp_sel.size());
    for (int i = 0; i < exp_sel.size() && i < sw_sel.size(); i++)
      chk("poll_channel", 32'(sw_sel[i]), 32'(exp_sel[i]));
  endtask

  task automatic pop_check(input string nm, input logic exp_valid, input logic [31:0] exp_word);
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
    chk({nm, "_valid"}, 32'(bus.rd_valid), 32'(exp_valid));
    if (exp_valid) chk(nm, bus.rd_data, exp_word);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  typedef struct {
    logic [NCH-1:0] mask;
    logic [15:0]    c0, c1, c2, c3;
    int             cycles;
    int             count;
    logic           miss;
  } vec_t;

  vec_t vt [4];

  logic [15:0] m_last [NCH];
  logic [31:0] m_q [$];
  logic        m_ovf, m_miss;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic any_os, any_sd;
    logic [NCH-1:0] m;
    int r;

    vt[0] = '{4'h5, 16'd1, 16'd0, 16'd1, 16'd0, 6, 2, 1'b0};
    vt[1] = '{4'h5, 16'd1, 16'd0, 16'd1, 16'd0, 6, 2, 1'b0};
    vt[2] = '{4'h5, 16'd1, 16'd0, 16'd2, 16'd0, 6, 3, 1'b0};
    vt[3] = '{4'h1, 16'd4, 16'd0, 16'd2, 16'd0, 5, 4, 1'b1};

    reset = 1'b1; enable = 1'b0; clear = 1'b0; channel_mask = '0; bus.rd_en = 1'b0;
    for (int i = 0; i < NCH; i++) ch_cnt[i] = 16'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_output_sample", 32'(bus.output_sample), 32'd0);
    chk("rst_channel_select", 32'(bus.channel_select), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);
    chk("rst_fifo_empty", 32'(bus.fifo_empty), 32'd1);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_missed", 32'(missed), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);

    // Directed sweep table
    for (int i = 0; i < 4; i++) begin
      ch_cnt[0] = vt[i].c0; ch_cnt[1] = vt[i].c1; ch_cnt[2] = vt[i].c2; ch_cnt[3] = vt[i].c3;
      run_sweep(vt[i].mask, 0, -1);
      chk("tbl_sweep_cycles", sw_cycles, vt[i].cycles);
      check_sel(vt[i].mask);
      chk("tbl_fifo_count", 32'(bus.fifo_count), vt[i].count);
      chk("tbl_missed", 32'(missed), 32'(vt[i].miss));
      chk("tbl_overflow", 32'(overflow), 32'd0);
    end
    pop_check("tbl_pop0", 1'b1, mkword(0, 16'd1));
    @(posedge clk); #1;
    chk("rd_valid_single_cycle", 32'(bus.rd_valid), 32'd0);
    pop_check("tbl_pop1", 1'b1, mkword(2, 16'd1));
    pop_check("tbl_pop2", 1'b1, mkword(2, 16'd2));
    pop_check("tbl_pop3", 1'b1, mkword(0, 16'd4));
    pop_check("pop_empty", 1'b0, 32'd0);
    chk("pop_empty_no_ovf", 32'(overflow), 32'd0);
    pulse_clear();
    chk("clr_missed", 32'(missed), 32'd0);
    chk("clr_count", 32'(bus.fifo_count), 32'd0);
    chk("clr_empty", 32'(bus.fifo_empty), 32'd1);

    // FIFO full: push dropped while a pop happens the same cycle
    for (int c = 1; c <= 4; c++) begin
      ch_cnt[0] = 16'(c);
      run_sweep(4'h1, 0, -1);
    end
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    ch_cnt[0] = 16'd5;
    run_sweep(4'h1, 0, 1);
    chk("full_overflow", 32'(overflow), 32'd1);
    chk("full_count_after", 32'(bus.fifo_count), 32'd3);
    chk("full_pop_valid", 32'(sw_rdv), 32'd1);
    chk("full_pop_word", sw_rdw, mkword(0, 16'd1));
    ch_cnt[0] = 16'd6;
    run_sweep(4'h1, 0, -1);
    chk("after_full_count", 32'(bus.fifo_count), 32'd4);
    chk("after_full_missed", 32'(missed), 32'd0);
    pop_check("drain0", 1'b1, mkword(0, 16'd2));
    pop_check("drain1", 1'b1, mkword(0, 16'd3));
    pop_check("drain2", 1'b1, mkword(0, 16'd4));
    pop_check("drain3", 1'b1, mkword(0, 16'd6));
    chk("overflow_sticky", 32'(overflow), 32'd1);
    pulse_clear();

    // Counter wrap
    ch_cnt[1] = 16'hFFFF;
    run_sweep(4'h2, 0, -1);
    ch_cnt[1] = 16'h0000;
    run_sweep(4'h2, 0, -1);
    chk("wrap_count", 32'(bus.fifo_count), 32'd2);
    chk("wrap_missed", 32'(missed), 32'd0);
    pop_check("wrap_pop0", 1'b1, mkword(1, 16'hFFFF));
    pop_check("wrap_pop1", 1'b1, mkword(1, 16'h0000));
    pulse_clear();

    // enable dropped during CAP of channel 1: sweep still completes, then idle
    for (int i = 0; i < NCH; i++) ch_cnt[i] = 16'(10 + i);
    run_sweep(4'hF, 3, -1);
    chk("endrop_cycles", sw_cycles, 8);
    check_sel(4'hF);
    any_os = 1'b0; any_sd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      any_os |= bus.output_sample;
      any_sd |= sweep_done;
    end
    chk("endrop_idle_os", 32'(any_os), 32'd0);
    chk("endrop_idle_sd", 32'(any_sd), 32'd0);
    pulse_clear();

    // clear mid-sweep: FSM idles, no sweep_done, nothing pushed
    for (int i = 0; i < NCH; i++) ch_cnt[i] = 16'(20 + i);
    channel_mask = 4'hF;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("midclr_requesting", 32'(bus.output_sample), 32'd1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    any_os = 1'b0; any_sd = 1'b0;
    for (int k = 0; k < 10; k++) begin
      any_os |= bus.output_sample;
      any_sd |= sweep_done;
      @(posedge clk); #1;
    end
    chk("midclr_os", 32'(any_os), 32'd0);
    chk("midclr_sd", 32'(any_sd), 32'd0);
    chk("midclr_count", 32'(bus.fifo_count), 32'd0);

    // Random sweeps against the reference model
    pulse_clear();
    for (int i = 0; i < NCH; i++) m_last[i] = 16'd0;
    m_q.delete(); m_ovf = 1'b0; m_miss = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        pulse_clear();
        for (int i = 0; i < NCH; i++) m_last[i] = 16'd0;
        m_q.delete(); m_ovf = 1'b0; m_miss = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        r = int'($urandom_range(0, 3));
        case (r)
          1: ch_cnt[i] = ch_cnt[i] + 16'd1;
          2: ch_cnt[i] = ch_cnt[i] + 16'($urandom_range(2, 5));
          3: ch_cnt[i] = 16'hFFFF;
          default: ;
        endcase
      end
      m = NCH'($urandom_range(0, 15));
      run_sweep(m, 0, -1);
      for (int i = 0; i < NCH; i++) begin
        if (m[i] && ch_cnt[i] != m_last[i]) begin
          if (m_q.size() < DEPTH) m_q.push_back(mkword(i, ch_cnt[i]));
          else m_ovf = 1'b1;
          if (m_last[i] != 16'd0 && 16'(ch_cnt[i] - m_last[i]) > 16'd1) m_miss = 1'b1;
          m_last[i] = ch_cnt[i];
        end
      end
      chk("rnd_cycles", sw_cycles, sweep_len(m));
      check_sel(m);
      chk("rnd_count", 32'(bus.fifo_count), m_q.size());
      chk("rnd_empty", 32'(bus.fifo_empty), 32'(m_q.size() == 0));
      chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
      chk("rnd_missed", 32'(missed), 32'(m_miss));
      r = int'($urandom_range(0, 5));
      for (int j = 0; j < r; j++) begin
        if (m_q.size() > 0) pop_check("rnd_pop", 1'b1, m_q.pop_front());
        else pop_check("rnd_pop", 1'b0, 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
